// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: default widths, ALU opcodes
// and the arbiter state encoding.
package alu_pkg;

  localparam int ALU_W   = 8;
  localparam int ALU_OPW = 3;

  localparam logic [ALU_OPW-1:0] OP_ADD = 3'b000;
  localparam logic [ALU_OPW-1:0] OP_SUB = 3'b001;
  localparam logic [ALU_OPW-1:0] OP_AND = 3'b010;
  localparam logic [ALU_OPW-1:0] OP_OR  = 3'b011;
  localparam logic [ALU_OPW-1:0] OP_XOR = 3'b100;
  localparam logic [ALU_OPW-1:0] OP_NOT = 3'b101;
  localparam logic [ALU_OPW-1:0] OP_SHL = 3'b110;
  localparam logic [ALU_OPW-1:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // One-hot grant vector for requester index idx.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin pick with lock: a held lock restricts the grant to its
// owner; a lock whose owner is not requesting falls back to normal arbitration.
module rr_arb2
  import alu_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_lock_en,
  input  logic       i_lock_owner,
  output logic [1:0] o_gnt
);

  logic w_lock_hold;

  assign w_lock_hold = i_lock_en & i_req[i_lock_owner];

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    o_gnt = 2'b00;
    if (w_lock_hold) begin
      o_gnt = onehot2(i_lock_owner);
    end else begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = onehot2(~i_last);
        default: o_gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between execute (requester 0) and the
// address/PC helper (requester 1): captures operands, registers the result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W   = ALU_W,
  parameter int OPW = ALU_OPW
) (
  input  logic           i_clk,
  input  logic           i_rst,

  input  logic           i_req0,
  input  logic [OPW-1:0] i_op0,
  input  logic [W-1:0]   i_a0,
  input  logic [W-1:0]   i_b0,
  input  logic           i_lock0,
  output logic           o_gnt0,
  output logic           o_done0,

  input  logic           i_req1,
  input  logic [OPW-1:0] i_op1,
  input  logic [W-1:0]   i_a1,
  input  logic [W-1:0]   i_b1,
  input  logic           i_lock1,
  output logic           o_gnt1,
  output logic           o_done1,

  output logic [W-1:0]   o_result,
  output logic           o_zero,

  output logic [W-1:0]   o_alu_a,
  output logic [W-1:0]   o_alu_b,
  output logic [OPW-1:0] o_alu_op,
  input  logic [W-1:0]   i_alu_out
);

  arb_state_t     r_state;
  arb_state_t     w_state_nxt;
  logic           r_owner;
  logic           r_last;
  logic           r_lock;
  logic [W-1:0]   r_alu_a;
  logic [W-1:0]   r_alu_b;
  logic [OPW-1:0] r_alu_op;
  logic [W-1:0]   r_result;
  logic           r_zero;

  logic [1:0]     w_req;
  logic [1:0]     w_pick;
  logic [1:0]     w_gnt;
  logic           w_arb;
  logic           w_granted;
  logic           w_sel;

  assign w_req = {i_req1, i_req0};

  rr_arb2 u_rr_arb2 (
    .i_req        (w_req),
    .i_last       (r_last),
    .i_lock_en    (r_lock),
    .i_lock_owner (r_owner),
    .o_gnt        (w_pick)
  );

  // Grants exist only in arb cycles and are suppressed while reset is held.
  assign w_gnt     = (w_arb && !i_rst) ? w_pick : 2'b00;
  assign w_granted = |w_gnt;
  assign w_sel     = w_gnt[1];

  always_comb begin
    w_state_nxt = r_state;
    w_arb       = 1'b0;
    case (r_state)
      IDLE: begin
        w_arb       = 1'b1;
        w_state_nxt = w_granted ? EXEC : IDLE;
      end
      EXEC: w_state_nxt = DONE;
      DONE: begin
        w_arb       = 1'b1;
        w_state_nxt = w_granted ? EXEC : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_lock   <= 1'b0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else if (w_granted) begin
      r_owner  <= w_sel;
      r_last   <= w_sel;
      r_lock   <= w_sel ? i_lock1 : i_lock0;
      r_alu_a  <= w_sel ? i_a1 : i_a0;
      r_alu_b  <= w_sel ? i_b1 : i_b0;
      r_alu_op <= w_sel ? i_op1 : i_op0;
    end else if (w_arb && r_lock && !w_req[r_owner]) begin
      // Owner went idle in an arb cycle: the lock lapses.
      r_lock <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (r_state == EXEC) begin
      r_result <= i_alu_out;
      r_zero   <= (i_alu_out == '0);
    end
  end

  assign o_gnt0   = w_gnt[0];
  assign o_gnt1   = w_gnt[1];
  assign o_done0  = (r_state == DONE) && !r_owner;
  assign o_done1  = (r_state == DONE) &&  r_owner;
  assign o_result = r_result;
  assign o_zero   = r_zero;
  assign o_alu_a  = r_alu_a;
  assign o_alu_b  = r_alu_b;
  assign o_alu_op = r_alu_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU closing the loop.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W   = 8;
  localparam int OPW = 3;

  logic           clk;
  logic           rst;
  logic           req0, req1, lock0, lock1;
  logic [OPW-1:0] op0, op1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           gnt0, gnt1, done0, done1;
  logic [W-1:0]   result;
  logic           zero;
  logic [W-1:0]   alu_a, alu_b, alu_out;
  logic [OPW-1:0] alu_op;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter #(.W(W), .OPW(OPW)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req0    (req0),
    .i_op0     (op0),
    .i_a0      (a0),
    .i_b0      (b0),
    .i_lock0   (lock0),
    .o_gnt0    (gnt0),
    .o_done0   (done0),
    .i_req1    (req1),
    .i_op1     (op1),
    .i_a1      (a1),
    .i_b1      (b1),
    .i_lock1   (lock1),
    .o_gnt1    (gnt1),
    .o_done1   (done1),
    .o_result  (result),
    .o_zero    (zero),
    .o_alu_a   (alu_a),
    .o_alu_b   (alu_b),
    .o_alu_op  (alu_op),
    .i_alu_out (alu_out)
  );

  // Behavioural ALU standing in for the real instance.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      OP_ADD: alu_out = alu_a + alu_b;
      OP_SUB: alu_out = alu_a - alu_b;
      OP_AND: alu_out = alu_a & alu_b;
      OP_OR:  alu_out = alu_a | alu_b;
      OP_XOR: alu_out = alu_a ^ alu_b;
      OP_NOT: alu_out = ~alu_a;
      OP_SHL: alu_out = alu_a << 1;
      OP_SHR: alu_out = alu_a >> 1;
      default: alu_out = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    op0 = OP_ADD; op1 = OP_ADD; a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // Reset: grants suppressed even with a request pending.
    #2;
    check("rst_gnt0", gnt0, 0);
    tick(); tick();
    check("rst_done0", done0, 0);
    check("rst_done1", done1, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    req0 = 1'b0;
    rst  = 1'b0;

    // Single ADD from requester 0: 5 + 3 = 8.
    req0 = 1'b1; op0 = OP_ADD; a0 = 8'h05; b0 = 8'h03;
    #1;
    check("t1_gnt0", gnt0, 1);
    check("t1_gnt1", gnt1, 0);
    tick();
    req0 = 1'b0;
    #1;
    check("t1_alu_a", alu_a, 8'h05);
    check("t1_alu_b", alu_b, 8'h03);
    check("t1_alu_op", alu_op, OP_ADD);
    check("t1_exec_done0", done0, 0);
    tick();
    check("t1_done0", done0, 1);
    check("t1_done1", done1, 0);
    check("t1_result", result, 8'h08);
    check("t1_zero", zero, 0);
    tick();
    check("t1_idle_done0", done0, 0);
    check("t1_idle_alu_a_hold", alu_a, 8'h05);
    check("t1_idle_result_hold", result, 8'h08);

    // Fresh reset so requester 0 wins the first tie again.
    rst = 1'b1; #1; rst = 1'b0;
    check("t2_rst_result", result, 0);

    // Both held: 0,1,0 alternation; FF+01 wraps to 0 with Zero set.
    req0 = 1'b1; op0 = OP_ADD; a0 = 8'hFF; b0 = 8'h01;
    req1 = 1'b1; op1 = OP_ADD; a1 = 8'h10; b1 = 8'h20;
    #1;
    check("t2_gnt0_first", gnt0, 1);
    check("t2_gnt1_first", gnt1, 0);
    tick();
    check("t2_exec_gnt0", gnt0, 0);
    check("t2_exec_gnt1", gnt1, 0);
    tick();
    check("t2_done0", done0, 1);
    check("t2_result0", result, 8'h00);
    check("t2_zero0", zero, 1);
    check("t2_gnt1_second", gnt1, 1);
    check("t2_gnt0_second", gnt0, 0);
    tick();
    tick();
    check("t2_done1", done1, 1);
    check("t2_done0_low", done0, 0);
    check("t2_result1", result, 8'h30);
    check("t2_zero1", zero, 0);
    check("t2_gnt0_third", gnt0, 1);
    check("t2_gnt1_third", gnt1, 0);
    tick();
    tick();
    check("t2_done0_again", done0, 1);
    check("t2_gnt1_fourth", gnt1, 1);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    check("t2_withdraw_gnt1", gnt1, 0);
    tick();

    // Lock by requester 0 across three ops while requester 1 waits.
    req0 = 1'b1; lock0 = 1'b1; op0 = OP_ADD; a0 = 8'h01; b0 = 8'h01;
    #1;
    check("t3_gnt0_a", gnt0, 1);
    tick();
    req1 = 1'b1; op1 = OP_ADD; a1 = 8'h40; b1 = 8'h02;
    a0 = 8'h02; b0 = 8'h02;
    #1;
    check("t3_exec_gnt1", gnt1, 0);
    tick();
    check("t3_done0_a", done0, 1);
    check("t3_result_a", result, 8'h02);
    check("t3_gnt0_b", gnt0, 1);
    check("t3_gnt1_b", gnt1, 0);
    tick();
    a0 = 8'h03; b0 = 8'h03; lock0 = 1'b0;
    tick();
    check("t3_result_b", result, 8'h04);
    check("t3_gnt0_c", gnt0, 1);
    check("t3_gnt1_c", gnt1, 0);
    tick();
    req0 = 1'b0;
    tick();
    check("t3_result_c", result, 8'h06);
    check("t3_done0_c", done0, 1);
    check("t3_gnt1_after_unlock", gnt1, 1);
    check("t3_gnt0_after_unlock", gnt0, 0);
    tick();
    req1 = 1'b0;
    tick();
    check("t3_done1", done1, 1);
    check("t3_result1", result, 8'h42);
    tick();

    // Lock owner 0 drops its request in DONE; requester 1 granted same cycle.
    req0 = 1'b1; lock0 = 1'b1; op0 = OP_ADD; a0 = 8'h0F; b0 = 8'hF1;
    #1;
    check("t4_gnt0", gnt0, 1);
    tick();
    req1 = 1'b1; op1 = OP_SUB; a1 = 8'h50; b1 = 8'h20;
    tick();
    check("t4_done0", done0, 1);
    check("t4_result0", result, 8'h00);
    check("t4_zero0", zero, 1);
    req0 = 1'b0;
    #1;
    check("t4_gnt1_release", gnt1, 1);
    check("t4_gnt0_release", gnt0, 0);
    tick();
    req1 = 1'b0;
    tick();
    check("t4_done1", done1, 1);
    check("t4_result1", result, 8'h30);
    check("t4_zero1", zero, 0);
    tick();

    // Requester 1 withdraws while requester 0 holds a locked grant.
    req0 = 1'b1; lock0 = 1'b1; op0 = OP_XOR; a0 = 8'hF0; b0 = 8'h3C;
    #1;
    check("t6_gnt0", gnt0, 1);
    tick();
    req1 = 1'b1; op1 = OP_ADD; a1 = 8'h01; b1 = 8'h01;
    #1;
    check("t6_exec_gnt1", gnt1, 0);
    tick();
    check("t6_done0", done0, 1);
    check("t6_result", result, 8'hCC);
    check("t6_locked_gnt1", gnt1, 0);
    check("t6_locked_gnt0", gnt0, 1);
    req1 = 1'b0; lock0 = 1'b0;
    tick();
    req0 = 1'b0;
    tick();
    check("t6_done0_b", done0, 1);
    check("t6_done1_b", done1, 0);
    tick();
    check("t6_idle_done1", done1, 0);
    check("t6_idle_gnt1", gnt1, 0);
    check("t6_idle_result", result, 8'hCC);

    // Reset during EXEC discards the operation.
    req0 = 1'b1; op0 = OP_ADD; a0 = 8'h22; b0 = 8'h11;
    #1;
    check("t5_gnt0", gnt0, 1);
    tick();
    req0 = 1'b0;
    rst  = 1'b1;
    #1;
    check("t5_rst_done0", done0, 0);
    check("t5_rst_result", result, 0);
    check("t5_rst_zero", zero, 0);
    check("t5_rst_alu_a", alu_a, 0);
    rst = 1'b0;
    tick();
    check("t5_no_done0", done0, 0);
    check("t5_no_done1", done1, 0);
    check("t5_result_cleared", result, 0);
    tick();
    check("t5_still_no_done0", done0, 0);
    req0 = 1'b1;
    #1;
    check("t5_fresh_gnt0", gnt0, 1);
    tick();
    req0 = 1'b0;
    tick();
    check("t5_fresh_done0", done0, 1);
    check("t5_fresh_result", result, 8'h33);
    check("t5_fresh_zero", zero, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
